// File: rtl/digct_bist_pkg.sv
// digct_bist_pkg: shared types, sizes and the DigCt golden function for the BIST controller
package digct_bist_pkg;
  localparam int VEC_W = 5;
  localparam int NVEC = 32;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  // Returns {OUT3, OUT2, OUT1} for cell inputs v[0]=IN1 .. v[4]=IN5
  function automatic logic [2:0] digct_golden(input logic [VEC_W-1:0] v);
    return {~v[3] | v[2] | v[4], ~(v[1] & v[2]), v[0] | v[1] | ~v[2]};
  endfunction
endpackage

// File: rtl/digct_bist_ctrl_if.sv
// digct_bist_ctrl_if: request/result handshake and cell-facing signals of the BIST controller
interface digct_bist_ctrl_if import digct_bist_pkg::*; #(parameter int ERR_W = 6);
  logic start, dir, hold, busy, done, pass;
  logic [VEC_W-1:0] vec, first_err;
  logic [2:0] dut_out;
  logic [ERR_W-1:0] err_cnt;
  modport master (output start, dir, hold, dut_out, input vec, busy, done, pass, err_cnt, first_err);
  modport slave (input start, dir, hold, dut_out, output vec, busy, done, pass, err_cnt, first_err);
endinterface

// File: rtl/digct_bist_dly.sv
// digct_bist_dly: LAT-deep {valid, vec} delay line aligning issued vectors with the cell response
module digct_bist_dly import digct_bist_pkg::*; #(parameter int LAT = 1) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [VEC_W-1:0] vec_i,
  output logic             valid_o,
  output logic [VEC_W-1:0] vec_o
);
  logic [LAT-1:0] valid_q;
  logic [LAT-1:0][VEC_W-1:0] vec_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      vec_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      vec_q[0] <= vec_i;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        vec_q[i] <= vec_q[i-1];
      end
    end
  end
  assign valid_o = valid_q[LAT-1];
  assign vec_o = vec_q[LAT-1];
endmodule

// File: rtl/digct_bist_ctrl.sv
// digct_bist_ctrl: sweeps the DigCt input space, compares responses, reports count/pass via start/busy/done.
// Define DIGCT_BIST_FIRST_ERR_EN to keep the first-mismatch vector capture; otherwise FIRST_ERR reads 0.
module digct_bist_ctrl import digct_bist_pkg::*; #(
  parameter int LAT = 1,
  parameter int ERR_W = 6
) (
  input logic clk_i,
  input logic rst_ni,
  digct_bist_ctrl_if.slave bus
);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  state_t state_q;
  logic [VEC_W-1:0] vec_q, dvec;
  logic [ERR_W-1:0] err_q, err_d;
  logic [CW-1:0] cnt_q;
  logic dir_q, busy_q, done_q, pass_q, issue, last, dvalid, mis, accept;
  assign accept = state_q == S_IDLE && bus.start;
  assign issue = state_q == S_RUN && !bus.hold;
  assign last = vec_q == (dir_q ? '0 : VEC_W'(NVEC - 1));
  digct_bist_dly #(.LAT(LAT)) u_dly (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(issue), .vec_i(vec_q),
    .valid_o(dvalid), .vec_o(dvec)
  );
  assign mis = dvalid && bus.dut_out != digct_golden(dvec);
  assign err_d = (mis && err_q != '1) ? err_q + 1'b1 : err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      vec_q <= '0;
      dir_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q <= '0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.start) begin
          state_q <= S_RUN;
          vec_q <= bus.dir ? '1 : '0;
          dir_q <= bus.dir;
          busy_q <= 1'b1;
          pass_q <= 1'b0;
          err_q <= '0;
        end
        S_RUN: if (!bus.hold) begin
          if (last) begin
            state_q <= S_DRAIN;
            cnt_q <= '0;
          end else vec_q <= dir_q ? vec_q - 1'b1 : vec_q + 1'b1;
        end
        S_DRAIN: if (cnt_q == CW'(LAT - 1)) begin
          // last in-flight compare lands on this edge, so judge PASS on err_d
          state_q <= S_DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          pass_q <= err_d == '0;
        end else cnt_q <= cnt_q + 1'b1;
        default: state_q <= S_IDLE;
      endcase
    end
  end
`ifdef DIGCT_BIST_FIRST_ERR_EN
  logic [VEC_W-1:0] first_q;
  logic seen_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      first_q <= '0;
      seen_q <= 1'b0;
    end else if (accept) begin
      first_q <= '0;
      seen_q <= 1'b0;
    end else if (mis && !seen_q) begin
      first_q <= dvec;
      seen_q <= 1'b1;
    end
  end
  assign bus.first_err = first_q;
`else
  assign bus.first_err = '0;
`endif
  assign bus.vec = vec_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.pass = pass_q;
  assign bus.err_cnt = err_q;
endmodule

// File: tb/tb_digct_bist_ctrl.sv
// tb_digct_bist_ctrl: directed vector table plus reset and saturation sequences for digct_bist_ctrl
module tb_digct_bist_ctrl;
  typedef struct {
    logic dir;
    logic fault;
    int h_at;
    int h_len;
    int exp_k;
    int exp_err;
    logic exp_pass;
    logic [4:0] exp_first;
  } vec_t;
`ifdef DIGCT_BIST_FIRST_ERR_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, dir = 1'b0, hold = 1'b0, fault = 1'b0;
  logic [2:0] a_cell = '0, b_cell = '0;
  int n_run = 0, n_fail = 0;
  vec_t tbl[6];
  always #5 clk = ~clk;
  digct_bist_ctrl_if #(.ERR_W(6)) a();
  digct_bist_ctrl_if #(.ERR_W(3)) b();
  digct_bist_ctrl #(.LAT(1), .ERR_W(6)) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(a));
  digct_bist_ctrl #(.LAT(1), .ERR_W(3)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(b));
  function automatic logic [2:0] ref_cell(input logic [4:0] v);
    logic [2:0] r;
    r[0] = v[0] | v[1] | ~v[2];
    r[1] = ~(v[1] & v[2]);
    r[2] = ~v[3] | v[2] | v[4];
    return r;
  endfunction
  // behavioural DigCt: one flop of latency; A optionally has OUT2 stuck at 1, B is fully inverted
  always @(posedge clk) begin
    a_cell <= fault ? (ref_cell(a.vec) | 3'b010) : ref_cell(a.vec);
    b_cell <= ~ref_cell(b.vec);
  end
  assign a.dut_out = a_cell;
  assign b.dut_out = b_cell;
  assign a.start = start;
  assign b.start = start;
  assign a.dir = dir;
  assign b.dir = dir;
  assign a.hold = hold;
  assign b.hold = hold;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run_sweep(input logic d, input int h_at, input int h_len, input int sp1, input int sp2,
                           output int done_k, output logic vec_ok, output logic post_ok);
    logic [4:0] exp;
    int issued;
    @(posedge clk); #1 start = 1'b1; dir = d;
    @(posedge clk); #1 start = 1'b0; dir = ~d;
    exp = d ? 5'd31 : 5'd0;
    issued = 0;
    done_k = 0;
    vec_ok = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      hold = h_len > 0 && k >= h_at && k < h_at + h_len;
      start = (k == sp1) || (k == sp2);
      @(negedge clk);
      if (issued < 32) begin
        if (a.vec !== exp || a.busy !== 1'b1) vec_ok = 1'b0;
        if (!hold) begin
          issued++;
          if (issued < 32) exp = d ? exp - 5'd1 : exp + 5'd1;
        end
      end
      if (a.done === 1'b1) begin
        done_k = k;
        if (a.busy !== 1'b0) vec_ok = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    hold = 1'b0;
    start = 1'b0;
    @(negedge clk);
    post_ok = a.done === 1'b0 && a.busy === 1'b0;
  endtask
  initial begin
    int done_k, ndone;
    logic vec_ok, post_ok;
    tbl[0] = '{1'b0, 1'b0, 0, 0, 34, 0, 1'b1, 5'd0};
    tbl[1] = '{1'b1, 1'b0, 0, 0, 34, 0, 1'b1, 5'd0};
    tbl[2] = '{1'b0, 1'b1, 0, 0, 34, 8, 1'b0, FE ? 5'd6 : 5'd0};
    tbl[3] = '{1'b1, 1'b1, 0, 0, 34, 8, 1'b0, FE ? 5'd31 : 5'd0};
    tbl[4] = '{1'b0, 1'b0, 11, 5, 39, 0, 1'b1, 5'd0};
    tbl[5] = '{1'b1, 1'b1, 3, 2, 36, 8, 1'b0, FE ? 5'd31 : 5'd0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vec", a.vec, 0);
    chk("rst_busy", a.busy, 0);
    chk("rst_done", a.done, 0);
    chk("rst_pass", a.pass, 0);
    chk("rst_err", a.err_cnt, 0);
    chk("rst_first", a.first_err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fault = tbl[i].fault;
      run_sweep(tbl[i].dir, tbl[i].h_at, tbl[i].h_len, 0, 0, done_k, vec_ok, post_ok);
      chk($sformatf("t%0d_done_cycle", i), done_k, tbl[i].exp_k);
      chk($sformatf("t%0d_vec_seq", i), vec_ok, 1);
      chk($sformatf("t%0d_done_pulse", i), post_ok, 1);
      chk($sformatf("t%0d_err", i), a.err_cnt, tbl[i].exp_err);
      chk($sformatf("t%0d_pass", i), a.pass, tbl[i].exp_pass);
      chk($sformatf("t%0d_first", i), a.first_err, tbl[i].exp_first);
    end
    // START pulses in RUN and DRAIN must not disturb the run; B saturates
    fault = 1'b0;
    run_sweep(1'b0, 0, 0, 5, 33, done_k, vec_ok, post_ok);
    chk("sp_done_cycle", done_k, 34);
    chk("sp_vec_seq", vec_ok, 1);
    chk("sp_idle_after", post_ok, 1);
    chk("sp_pass", a.pass, 1);
    chk("sat_err", b.err_cnt, 7);
    chk("sat_pass", b.pass, 0);
    // asynchronous reset in mid-run
    fault = 1'b1;
    @(posedge clk); #1 start = 1'b1; dir = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("mid_vec", a.vec, 15);
    chk("mid_err", a.err_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vec", a.vec, 0);
    chk("arst_busy", a.busy, 0);
    chk("arst_err", a.err_cnt, 0);
    chk("arst_first", a.first_err, 0);
    chk("arst_pass", a.pass, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (a.done === 1'b1 || a.busy === 1'b1) ndone++;
    end
    chk("arst_no_done", ndone, 0);
    fault = 1'b0;
    run_sweep(1'b0, 0, 0, 0, 0, done_k, vec_ok, post_ok);
    chk("rerun_done_cycle", done_k, 34);
    chk("rerun_vec_seq", vec_ok, 1);
    chk("rerun_pass", a.pass, 1);
    chk("rerun_err", a.err_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
